// File: rtl/reglk_ctrl_gen2.sv
// Register-lock controller: shadow lock words committed atomically to the active lock vector.
// Optional macro REGLK_STICKY_EN: commits OR shadow into active so lock bits can only be set.

module reglk_word #(
  parameter logic [31:0] WMASK = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sh_we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stg_we,
  input  logic        act_we,
  output logic [31:0] shadow_o,
  output logic [31:0] active_o
);
  logic [31:0] stage_q, bmask, merged;

  // WMASK keeps bits past the last peripheral permanently zero
  assign bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}} & WMASK;

`ifdef REGLK_STICKY_EN
  assign merged = active_o | shadow_o;
`else
  assign merged = shadow_o;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_o <= '0;
      stage_q  <= '0;
      active_o <= '0;
    end else begin
      if (sh_we)  shadow_o <= (shadow_o & ~bmask) | (wdata & bmask);
      if (stg_we) stage_q  <= merged;
      if (act_we) active_o <= stage_q;
    end
  end
endmodule

module reglk_ctrl_gen2 #(
  parameter int NB_PERIPH = 24,
  parameter int LK_BITS   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         reg_valid_i,
  input  logic                         reg_write_i,
  input  logic [11:0]                  reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  input  logic [3:0]                   reg_wstrb_i,
  output logic [31:0]                  reg_rdata_o,
  output logic                         reg_ready_o,
  output logic                         reg_error_o,
  output logic [NB_PERIPH*LK_BITS-1:0] reglk_ctrl_o,
  output logic                         commit_done_o
);
  localparam int TOT      = NB_PERIPH * LK_BITS;
  localparam int NB_WORDS = (TOT + 31) / 32;
  localparam int IW       = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

  reg_req_t                     req;
  state_e                       state_q, state_d;
  logic [IW-1:0]                cnt_q, cnt_d;
  logic                         frozen_q;
  logic [NB_WORDS-1:0][31:0]    shadow, active;
  logic [NB_WORDS-1:0]          sh_we, stg_we;
  logic [NB_WORDS*32-1:0]       act_flat;
  logic [9:0]                   widx;
  logic [IW-1:0]                wsel;
  logic is_sh, is_ctrl, is_stat, is_act, busy, pending, wr, ctrl_wr, start, act_we;
  logic unused_addr;

  assign req = '{valid: reg_valid_i, write: reg_write_i, addr: reg_addr_i,
                 wdata: reg_wdata_i, wstrb: reg_wstrb_i};

  assign widx        = req.addr[11:2];
  assign wsel        = widx[IW-1:0];
  assign unused_addr = ^req.addr[1:0];
  assign is_sh   = widx < 10'(NB_WORDS);
  assign is_ctrl = widx == 10'h040;
  assign is_stat = widx == 10'h041;
  assign is_act  = (widx >= 10'h080) && (widx < 10'(128 + NB_WORDS));

  assign busy    = state_q != IDLE;
  assign pending = shadow != active;
  assign wr      = req.valid & req.write;
  assign ctrl_wr = wr & is_ctrl & ~frozen_q;
  assign start   = ctrl_wr & req.wdata[0] & ~busy;
  assign act_we  = state_q == DONE;

  for (genvar w = 0; w < NB_WORDS; w++) begin : g_word
    localparam logic [31:0] WMASK = (w == NB_WORDS - 1 && TOT % 32 != 0)
                                    ? ((32'h1 << (TOT % 32)) - 32'h1) : 32'hFFFF_FFFF;
    assign sh_we[w]  = wr & is_sh & ~frozen_q & ~busy & (wsel == IW'(w));
    assign stg_we[w] = (state_q == COPY) && (cnt_q == IW'(w));
    reglk_word #(.WMASK(WMASK)) u_word (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sh_we    (sh_we[w]),
      .wstrb    (req.wstrb),
      .wdata    (req.wdata),
      .stg_we   (stg_we[w]),
      .act_we   (act_we),
      .shadow_o (shadow[w]),
      .active_o (active[w])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frozen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ctrl_wr && req.wdata[1]) frozen_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = COPY;
        cnt_d   = '0;
      end
      COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(NB_WORDS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata_o = '0;
    if (is_sh)        reg_rdata_o = shadow[wsel];
    else if (is_stat) reg_rdata_o = {29'b0, busy, frozen_q, pending};
    else if (is_act)  reg_rdata_o = active[wsel];
  end

  // a COMMIT while busy is refused even though a FREEZE in the same write is taken
  always_comb begin
    reg_error_o = 1'b0;
    if (req.valid) begin
      if (is_sh)                  reg_error_o = req.write & (frozen_q | busy);
      else if (is_ctrl)           reg_error_o = req.write & (frozen_q | (busy & req.wdata[0]));
      else if (is_stat || is_act) reg_error_o = req.write;
      else                        reg_error_o = 1'b1;
    end
  end

  assign act_flat      = active;
  assign reglk_ctrl_o  = act_flat[TOT-1:0];
  assign commit_done_o = state_q == DONE;
  assign reg_ready_o   = 1'b1;
endmodule

// File: tb/tb_reglk_ctrl_gen2.sv
// Bench for reglk_ctrl_gen2: vector table, directed commit/freeze/reset sequences, random vs model.
module tb_reglk_ctrl_gen2;
  localparam int NP  = 24;
  localparam int LB  = 8;
  localparam int TOT = NP * LB;
  localparam int NW  = (TOT + 31) / 32;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           reg_valid, reg_write;
  logic [11:0]    reg_addr;
  logic [31:0]    reg_wdata, reg_rdata;
  logic [3:0]     reg_wstrb;
  logic           reg_ready, reg_error, commit_done;
  logic [TOT-1:0] reglk;

  always #5 clk = ~clk;

  reglk_ctrl_gen2 #(.NB_PERIPH(NP), .LK_BITS(LB)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .reg_valid_i(reg_valid), .reg_write_i(reg_write),
    .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
    .reg_rdata_o(reg_rdata), .reg_ready_o(reg_ready), .reg_error_o(reg_error),
    .reglk_ctrl_o(reglk), .commit_done_o(commit_done)
  );

  int vectors = 0, miscompares = 0;

  // reference model: register contents plus a countdown to the commit landing
  logic [31:0] sh_m [NW];
  logic [31:0] act_m[NW];
  bit          frz_m;
  int          rem_m;

  task automatic check(input string nm, input logic [255:0] a, input logic [255:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    if (w == NW - 1 && TOT % 32 != 0) return (32'h1 << (TOT % 32)) - 32'h1;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] a, input logic [31:0] s);
`ifdef REGLK_STICKY_EN
    return a | s;
`else
    return s;
`endif
  endfunction

  function automatic logic [TOT-1:0] act_vec();
    logic [NW*32-1:0] f;
    for (int i = 0; i < NW; i++) f[i*32 +: 32] = act_m[i];
    return f[TOT-1:0];
  endfunction

  function automatic bit pend_m();
    for (int i = 0; i < NW; i++) if (sh_m[i] != act_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_resp(input bit w, input logic [11:0] a, input logic [31:0] d,
                                   output logic [31:0] rd, output bit er);
    int  idx  = int'(a[11:2]);
    bit  busy = rem_m > 0;
    rd = '0;
    er = 1'b0;
    if (idx < NW) begin
      rd = sh_m[idx];
      er = w && (frz_m || busy);
    end else if (idx == 'h40) begin
      er = w && (frz_m || (busy && d[0]));
    end else if (idx == 'h41) begin
      rd = {29'b0, busy, frz_m, pend_m()};
      er = w;
    end else if (idx >= 'h80 && idx < 'h80 + NW) begin
      rd = act_m[idx - 'h80];
      er = w;
    end else begin
      er = 1'b1;
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    frz_m = 1'b0;
    rem_m = 0;
  endtask

  // one bus cycle: drive, sample at negedge against the model, then advance the model at the edge
  task automatic step(input bit v, input bit w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    bit          eer, busy;
    int          idx;
    reg_valid = v; reg_write = w; reg_addr = a; reg_wdata = d; reg_wstrb = s;
    @(negedge clk);
    exp_resp(w, a, d, erd, eer);
    rd = reg_rdata;
    er = reg_error;
    if (v && !w) check("model_rdata", reg_rdata, erd);
    if (v)       check("model_error", reg_error, eer);
    check("model_commit_done", commit_done, rem_m == 1);
    check("model_reglk", reglk, act_vec());
    check("ready", reg_ready, 1'b1);
    @(posedge clk);
    busy = rem_m > 0;
    if (rem_m > 0) begin
      rem_m--;
      if (rem_m == 0) for (int i = 0; i < NW; i++) act_m[i] = merge(act_m[i], sh_m[i]);
    end
    idx = int'(a[11:2]);
    if (v && w) begin
      if (idx < NW && !frz_m && !busy) begin
        for (int b = 0; b < 4; b++) if (s[b]) sh_m[idx][8*b +: 8] = d[8*b +: 8];
        sh_m[idx] &= wmask(idx);
      end else if (idx == 'h40 && !frz_m) begin
        if (d[0] && !busy) rem_m = NW + 1;
        if (d[1]) frz_m = 1'b1;
      end
    end
    #1;
    reg_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, output logic er);
    logic [31:0] rd;
    step(1, 1, a, d, 4'hF, rd, er);
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] e);
    logic [31:0] rd;
    logic        er;
    step(1, 0, a, 32'h0, 4'h0, rd, er);
    check(nm, rd, e);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < n; i++) step(0, 0, 12'h0, 32'h0, 4'h0, rd, er);
  endtask

  task automatic do_reset();
    reg_valid = 1'b0;
    rst_ni    = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit          w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] erd;
    bit          eer;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          dones;
    reg_valid = 0; reg_write = 0; reg_addr = 0; reg_wdata = 0; reg_wstrb = 0;

    tbl[0]  = '{0, 12'h104, 32'h0,         4'h0, 32'h0,         0};
    tbl[1]  = '{0, 12'h200, 32'h0,         4'h0, 32'h0,         0};
    tbl[2]  = '{1, 12'h004, 32'hFFFF_FFFF, 4'h2, 32'h0,         0};
    tbl[3]  = '{0, 12'h004, 32'h0,         4'h0, 32'h0000_FF00, 0};
    tbl[4]  = '{0, 12'h104, 32'h0,         4'h0, 32'h1,         0};
    tbl[5]  = '{0, 12'h300, 32'h0,         4'h0, 32'h0,         1};
    tbl[6]  = '{1, 12'h300, 32'h1234,      4'hF, 32'h0,         1};
    tbl[7]  = '{1, 12'h104, 32'h7,         4'hF, 32'h0,         1};
    tbl[8]  = '{1, 12'h200, 32'hFFFF,      4'hF, 32'h0,         1};
    tbl[9]  = '{0, 12'h100, 32'h0,         4'h0, 32'h0,         0};
    tbl[10] = '{1, 12'h018, 32'hFFFF,      4'hF, 32'h0,         1};
    tbl[11] = '{0, 12'h218, 32'h0,         4'h0, 32'h0,         1};
    tbl[12] = '{1, 12'h000, 32'hA5A5_0F0F, 4'hF, 32'h0,         0};
    tbl[13] = '{0, 12'h000, 32'h0,         4'h0, 32'hA5A5_0F0F, 0};
    tbl[14] = '{0, 12'h204, 32'h0,         4'h0, 32'h0,         0};

    rst_ni = 1'b0;
    #2;
    check("reset_reglk", reglk, '0);
    check("reset_done", commit_done, 1'b0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rd, er);
      if (!tbl[i].w) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
      check($sformatf("tbl%0d_error", i), er, tbl[i].eer);
    end

    // basic commit at edge N, busy-time write and status
    wr(12'h100, 32'h1, er);
    check("commit_err", er, 1'b0);
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("commit_reglk_k%0d", k), reglk[31:0], (k - 1 >= 7) ? 32'hA5A5_0F0F : 32'h0);
      if (commit_done) begin
        dones++;
        check("commit_done_cycle", k, 7);
      end
      if (k == 1) begin
        wr(12'h008, 32'h1234_5678, er);
        check("busy_write_err", er, 1'b1);
      end else if (k == 2) rd_chk("busy_status", 12'h104, 32'h5);
      else idle(1);
    end
    check("commit_done_count", dones, 1);
    rd_chk("shadow2_kept", 12'h008, 32'h0);
    rd_chk("status_after", 12'h104, 32'h0);
    rd_chk("active0", 12'h200, 32'hA5A5_0F0F);
    rd_chk("active1", 12'h204, 32'h0000_FF00);

    // merge rule
    do_reset();
    wr(12'h000, 32'h0000_00FF, er);
    wr(12'h100, 32'h1, er);
    idle(8);
    wr(12'h000, 32'h0000_0F00, er);
    wr(12'h100, 32'h1, er);
    idle(8);
`ifdef REGLK_STICKY_EN
    rd_chk("merge_active0", 12'h200, 32'h0000_0FFF);
`else
    rd_chk("merge_active0", 12'h200, 32'h0000_0F00);
`endif

    // reset mid-commit
    do_reset();
    wr(12'h000, 32'h55, er);
    wr(12'h100, 32'h1, er);
    idle(8);
    check("pre_rst_reglk", reglk[31:0], 32'h55);
    wr(12'h000, 32'hAA, er);
    wr(12'h100, 32'h1, er);
    idle(3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_reglk", reglk, '0);
    check("midrst_done", commit_done, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    rd_chk("midrst_status", 12'h104, 32'h0);
    rd_chk("midrst_shadow", 12'h000, 32'h0);
    idle(9);

    // random traffic against the model, freeze allowed only near the end
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      int          op = $urandom_range(0, 9);
      logic [11:0] a;
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom_range(0, 15));
      case (op)
        0, 1, 2, 3: step(1, 1, 12'(4 * $urandom_range(0, NW)), d, s, rd, er);
        4:          step(1, 0, 12'(4 * $urandom_range(0, NW - 1)), d, s, rd, er);
        5: begin
          d = 32'h1;
          if (it > 1300 && $urandom_range(0, 9) == 0) d = 32'h3;
          step(1, 1, 12'h100, d, 4'hF, rd, er);
        end
        6:          step(1, $urandom_range(0, 1) == 1, 12'h104, d, s, rd, er);
        7:          step(1, $urandom_range(0, 1) == 1, 12'(12'h200 + 4 * $urandom_range(0, NW - 1)), d, s, rd, er);
        8: begin
          a = 12'($urandom_range(0, 4095));
          step(1, $urandom_range(0, 1) == 1, a, d, s, rd, er);
        end
        default:    step(0, 0, 12'h0, 32'h0, 4'h0, rd, er);
      endcase
    end

    // freeze combined with a commit, then locked-out writes
    do_reset();
    wr(12'h000, 32'h33, er);
    wr(12'h100, 32'h3, er);
    check("frz_commit_err", er, 1'b0);
    rd_chk("frz_status_busy", 12'h104, 32'h7);
    idle(8);
    rd_chk("frz_status", 12'h104, 32'h2);
    wr(12'h000, 32'h1, er);
    check("frz_shadow_err", er, 1'b1);
    rd_chk("frz_shadow_kept", 12'h000, 32'h33);
    wr(12'h100, 32'h1, er);
    check("frz_commit_refused", er, 1'b1);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (commit_done) dones++;
      idle(1);
    end
    check("frz_no_done", dones, 0);
    rd_chk("frz_active0", 12'h200, 32'h33);
    rd_chk("frz_status_end", 12'h104, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
